// File: rtl/led_counter_pkg.sv
// Shared types and defaults for the LED tick counter: FSM state encoding
// and the default counter/synchronizer sizes.
package led_counter_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2
  } state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // Running state selected by a direction bit (1 = count down).
  function automatic state_e run_state(input logic dir_down);
    return dir_down ? DOWN : UP;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Raw push-button synchronizer followed by a registered rising-edge detector;
// a held button yields exactly one clk-wide press pulse.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   press_r;

  // Synchronizer chain, previous-level register and registered press pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r  <= {SYNC_STAGES{1'b0}};
      prev_r  <= 1'b0;
      press_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r  <= sync_r[SYNC_STAGES-1];
      press_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/led_tick_counter.sv
// Counts divider ticks onto the board LEDs; buttons control run/pause,
// direction and parallel load, with wrap or saturate at the limits.
module led_tick_counter
  import led_counter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             btn_run,
  input  logic             btn_dir,
  input  logic             btn_load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] leds,
  output logic             running,
  output logic             dir_down,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] LEDS_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LEDS_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] LEDS_ONE  = WIDTH'(1);

  logic run_press_s;
  logic dir_press_s;
  logic load_press_s;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] leds_r;
  logic [WIDTH-1:0] leds_nxt_s;
  logic             dir_down_r;
  logic             dir_nxt_s;
  logic             running_r;
  logic             wrap_pulse_r;
  logic             wrap_nxt_s;
  logic             sat_s;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (
    .clk(clk), .rst(rst), .async_in(btn_run), .press(run_press_s)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dir (
    .clk(clk), .rst(rst), .async_in(btn_dir), .press(dir_press_s)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk), .rst(rst), .async_in(btn_load), .press(load_press_s)
  );

  // Next-state, direction and counter datapath; load beats tick, saturation forces PAUSED.
  always_comb begin
    dir_nxt_s   = dir_down_r ^ dir_press_s;
    state_nxt_s = state_r;
    leds_nxt_s  = leds_r;
    wrap_nxt_s  = 1'b0;
    sat_s       = 1'b0;

    // Direction is resolved first so a simultaneous run press uses the new direction.
    case (state_r)
      PAUSED: begin
        if (run_press_s) state_nxt_s = run_state(dir_nxt_s);
        else             state_nxt_s = PAUSED;
      end
      UP, DOWN: begin
        if (run_press_s)      state_nxt_s = PAUSED;
        else if (dir_press_s) state_nxt_s = run_state(dir_nxt_s);
        else                  state_nxt_s = state_r;
      end
      default: state_nxt_s = PAUSED;
    endcase

    if (load_press_s) begin
      leds_nxt_s = load_val;
    end else if (tick_en && (state_r == UP)) begin
      if (leds_r == LEDS_MAX) begin
        wrap_nxt_s = 1'b1;
        if (wrap_en) leds_nxt_s = LEDS_ZERO;
        else         sat_s      = 1'b1;
      end else begin
        leds_nxt_s = leds_r + LEDS_ONE;
      end
    end else if (tick_en && (state_r == DOWN)) begin
      if (leds_r == LEDS_ZERO) begin
        wrap_nxt_s = 1'b1;
        if (wrap_en) leds_nxt_s = LEDS_MAX;
        else         sat_s      = 1'b1;
      end else begin
        leds_nxt_s = leds_r - LEDS_ONE;
      end
    end else begin
      leds_nxt_s = leds_r;
    end

    if (sat_s) state_nxt_s = PAUSED;
    else       state_nxt_s = state_nxt_s;
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= PAUSED;
      leds_r       <= LEDS_ZERO;
      dir_down_r   <= 1'b0;
      running_r    <= 1'b0;
      wrap_pulse_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      leds_r       <= leds_nxt_s;
      dir_down_r   <= dir_nxt_s;
      running_r    <= (state_nxt_s != PAUSED);
      wrap_pulse_r <= wrap_nxt_s;
    end
  end

  assign leds       = leds_r;
  assign running    = running_r;
  assign dir_down   = dir_down_r;
  assign wrap_pulse = wrap_pulse_r;

endmodule

// File: tb/tb_led_tick_counter.sv
// Directed, table-driven bench for led_tick_counter (WIDTH=8, SYNC_STAGES=2).
module tb_led_tick_counter;

  logic       clk;
  logic       rst;
  logic       tick_en;
  logic       btn_run;
  logic       btn_dir;
  logic       btn_load;
  logic [7:0] load_val;
  logic       wrap_en;
  logic [7:0] leds;
  logic       running;
  logic       dir_down;
  logic       wrap_pulse;

  int n_vec;
  int n_bad;

  typedef struct {
    logic       run;
    logic       dir;
    logic       load;
    logic [7:0] lv;
    logic       tick;
    logic       wrap;
    logic [7:0] e_leds;
    logic       e_run;
    logic       e_dir;
    logic       e_wp;
  } vec_t;

  vec_t vecs[$];

  led_tick_counter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en),
    .btn_run(btn_run), .btn_dir(btn_dir), .btn_load(btn_load),
    .load_val(load_val), .wrap_en(wrap_en),
    .leds(leds), .running(running), .dir_down(dir_down), .wrap_pulse(wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic run, input logic dir, input logic load, input logic [7:0] lv,
                     input logic tick, input logic wrap, input logic [7:0] el,
                     input logic er, input logic ed, input logic ew);
    vec_t v;
    v.run = run; v.dir = dir; v.load = load; v.lv = lv; v.tick = tick; v.wrap = wrap;
    v.e_leds = el; v.e_run = er; v.e_dir = ed; v.e_wp = ew;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] el, input logic er,
                       input logic ed, input logic ew);
    n_vec++;
    if ({leds, running, dir_down, wrap_pulse} !== {el, er, ed, ew}) begin
      n_bad++;
      $display("FAIL %s: got leds=%h running=%b dir_down=%b wrap_pulse=%b, want leds=%h running=%b dir_down=%b wrap_pulse=%b",
               name, leds, running, dir_down, wrap_pulse, el, er, ed, ew);
    end
  endtask

  task automatic drive(input logic run, input logic dir, input logic load, input logic [7:0] lv,
                       input logic tick, input logic wrap);
    btn_run = run; btn_dir = dir; btn_load = load; load_val = lv; tick_en = tick; wrap_en = wrap;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b0; tick_en = 1'b0; btn_run = 1'b0; btn_dir = 1'b0; btn_load = 1'b0;
    load_val = 8'h00; wrap_en = 1'b1;

    // run held 5 clks: one press, running at 3rd edge after first sample; 4 ticks
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    // load FE, then wrap up through FF to 00
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    // load 10, then load A5 coincident with a tick (tick dropped), then A6
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA6, 1'b1, 1'b0, 1'b0);
    // load 20; dir+run together -> dir_down=1, PAUSED; run -> DOWN; tick -> 1F
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 8'hA6, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b1, 1'b0);
    // load 01 in DOWN, wrap_en=0: 00, then saturate + pause, further ticks ignored
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h1F, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    // load 33, resume DOWN, one tick -> 32
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 8'h32, 1'b1, 1'b1, 1'b0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check("after_release", 8'h00, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].run, vecs[i].dir, vecs[i].load, vecs[i].lv, vecs[i].tick, vecs[i].wrap);
      check($sformatf("vec%0d", i), vecs[i].e_leds, vecs[i].e_run, vecs[i].e_dir, vecs[i].e_wp);
    end

    // asynchronous reset mid-count, between clock edges
    #2 rst = 1'b0;
    #1;
    check("async_rst_now", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("async_rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("post_rst_tick0", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("post_rst_tick1", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("post_rst_run0", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("post_rst_run1", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("post_rst_run2", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("post_rst_run3", 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("post_rst_count", 8'h01, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
